// File: rtl/pipe5_pkg.sv
// Shared definitions for the pipe5 core: opcodes, ALU ops, field positions, latch type
// and instruction-decode helpers. Opcodes setx/bex decode only when SETX_BEX_EN is defined.
package pipe5_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_MSB   = 16;
  localparam int TGT_MSB   = 26;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] result;
  } latch_t;

  localparam latch_t LATCH_NOP = '0;

  function automatic logic [4:0] opcode(input logic [31:0] ir);
    return ir[OPC_LSB +: 5];
  endfunction

  function automatic logic [4:0] aluop(input logic [31:0] ir);
    return ir[ALUOP_LSB +: 5];
  endfunction

  function automatic logic [31:0] imm_sext(input logic [31:0] ir);
    return {{(31 - IMM_MSB){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
  endfunction

  function automatic logic [31:0] jtarget(input logic [31:0] ir);
    return {{(31 - TGT_MSB){1'b0}}, ir[TGT_MSB:0]};
  endfunction

  // Register written by an instruction; 0 means no write.
  function automatic logic [4:0] dest_reg(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    case (opcode(ir))
      OP_RTYPE:        if (aluop(ir) <= ALU_SRA) d = ir[RD_LSB +: 5];
      OP_ADDI, OP_LW:  d = ir[RD_LSB +: 5];
      OP_JAL:          d = 5'd31;
`ifdef SETX_BEX_EN
      OP_SETX:         d = 5'd30;
`endif
      default:         d = 5'd0;
    endcase
    return d;
  endfunction

  // Register read on port A; 0 when the operand is unused.
  function automatic logic [4:0] src_a(input logic [31:0] ir);
    logic [4:0] s;
    s = 5'd0;
    case (opcode(ir))
      OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: s = ir[RS_LSB +: 5];
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  // Register read on port B; stores, compares and jr take rd here.
  function automatic logic [4:0] src_b(input logic [31:0] ir);
    logic [4:0] s;
    s = 5'd0;
    case (opcode(ir))
      OP_RTYPE:                    s = ir[RT_LSB +: 5];
      OP_SW, OP_BNE, OP_BLT, OP_JR: s = ir[RD_LSB +: 5];
`ifdef SETX_BEX_EN
      OP_BEX:                      s = 5'd30;
`endif
      default:                     s = 5'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipe5_alu.sv
// Combinational ALU for the pipe5 core: add/sub/and/or/sll/sra plus not-equal and
// signed less-than flags on (a, b).
module pipe5_alu
  import pipe5_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic [4:0]         op,
  input  logic [4:0]         shamt,
  output logic signed [31:0] y,
  output logic               ne,
  output logic               lt
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLL: y = a << shamt;
      ALU_SRA: y = a >>> shamt;
      default: y = '0;
    endcase
  end

  assign ne = (a != b);
  assign lt = (a < b);

endmodule

// File: rtl/pipe5_cpu.sv
// pipe5_cpu: 5-stage in-order integer core with full bypass and branch resolution in X.
// Define SETX_BEX_EN to decode the setx/bex instructions.
module pipe5_cpu
  import pipe5_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] address_imem,
  input  logic [XLEN-1:0] q_imem,
  output logic            ctrl_writeEnable,
  output logic [4:0]      ctrl_writeReg,
  output logic [4:0]      ctrl_readRegA,
  output logic [4:0]      ctrl_readRegB,
  output logic [XLEN-1:0] data_writeReg,
  input  logic [XLEN-1:0] data_readRegA,
  input  logic [XLEN-1:0] data_readRegB,
  output logic            wren,
  output logic [XLEN-1:0] address_dmem,
  output logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] q_dmem
);

  logic [31:0]        pc_fetch;
  logic [31:0]        pc_p0;
  logic               vld_p0;
  latch_t             dx_p1, xm_p2, mw_p3;
  latch_t             dx_next, xm_next;

  logic [31:0]        ir_p0, ir_p1;
  logic [4:0]         ra_p0, rb_p0;
  logic [4:0]         op_p1, ra_p1, rb_p1, dest_p1, dest_p2, dest_p3;
  logic signed [31:0] fa_p1, fb_p1;
  logic signed [31:0] alu_a, alu_b, alu_y;
  logic [4:0]         alu_op;
  logic               alu_ne, alu_lt;
  logic               taken, stall;
  logic [31:0]        target;
  logic signed [31:0] wb_data;
  logic               unused_fields;

  // ---- D: ROM output is the decode instruction; W result bypasses the register file
  assign ir_p0 = vld_p0 ? q_imem : NOP;
  assign ra_p0 = src_a(ir_p0);
  assign rb_p0 = src_b(ir_p0);
  assign ctrl_readRegA = ra_p0;
  assign ctrl_readRegB = rb_p0;

  always_comb begin
    dx_next       = LATCH_NOP;
    dx_next.pc    = pc_p0;
    dx_next.instr = ir_p0;
    dx_next.a     = (ra_p0 != 5'd0 && ra_p0 == dest_p3) ? wb_data : data_readRegA;
    dx_next.b     = (rb_p0 != 5'd0 && rb_p0 == dest_p3) ? wb_data : data_readRegB;
  end

  // ---- X: operand bypass, ALU, branch resolution
  assign ir_p1   = dx_p1.instr;
  assign op_p1   = opcode(ir_p1);
  assign ra_p1   = src_a(ir_p1);
  assign rb_p1   = src_b(ir_p1);
  assign dest_p1 = dest_reg(ir_p1);
  assign dest_p2 = dest_reg(xm_p2.instr);

  // M is younger than W, so its match is applied last.
  always_comb begin
    fa_p1 = dx_p1.a;
    fb_p1 = dx_p1.b;
    if (ra_p1 != 5'd0 && ra_p1 == dest_p3) fa_p1 = wb_data;
    if (rb_p1 != 5'd0 && rb_p1 == dest_p3) fb_p1 = wb_data;
    if (ra_p1 != 5'd0 && ra_p1 == dest_p2) fa_p1 = xm_p2.result;
    if (rb_p1 != 5'd0 && rb_p1 == dest_p2) fb_p1 = xm_p2.result;
  end

  always_comb begin
    alu_a  = fa_p1;
    alu_b  = fb_p1;
    alu_op = ALU_ADD;
    case (op_p1)
      OP_RTYPE:              alu_op = aluop(ir_p1);
      OP_ADDI, OP_SW, OP_LW: alu_b  = imm_sext(ir_p1);
      // Branches compare rd (port B) against rs (port A).
      OP_BNE, OP_BLT: begin
        alu_a = fb_p1;
        alu_b = fa_p1;
      end
      default: ;
    endcase
  end

  pipe5_alu u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .shamt (ir_p1[SHAMT_LSB +: 5]),
    .y     (alu_y),
    .ne    (alu_ne),
    .lt    (alu_lt)
  );

  always_comb begin
    taken  = 1'b0;
    target = dx_p1.pc + 32'd1 + imm_sext(ir_p1);
    case (op_p1)
      OP_BNE: taken = alu_ne;
      OP_BLT: taken = alu_lt;
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = jtarget(ir_p1);
      end
      OP_JR: begin
        taken  = 1'b1;
        target = fb_p1;
      end
`ifdef SETX_BEX_EN
      OP_BEX: begin
        taken  = (fb_p1 != 32'sd0);
        target = jtarget(ir_p1);
      end
`endif
      default: ;
    endcase
  end

  assign stall = !taken && op_p1 == OP_LW && dest_p1 != 5'd0 &&
                 (dest_p1 == ra_p0 || dest_p1 == rb_p0);

  always_comb begin
    xm_next        = LATCH_NOP;
    xm_next.pc     = dx_p1.pc;
    xm_next.instr  = ir_p1;
    xm_next.a      = fa_p1;
    xm_next.b      = fb_p1;
    xm_next.result = alu_y;
    case (op_p1)
      OP_JAL:  xm_next.result = dx_p1.pc + 32'd1;
`ifdef SETX_BEX_EN
      OP_SETX: xm_next.result = jtarget(ir_p1);
`endif
      default: ;
    endcase
  end

  // ---- F: the address presented this cycle is what the ROM returns to D next cycle
  assign address_imem = reset ? '0 : taken ? target : stall ? pc_p0 : pc_fetch;

  // ---- M: data RAM interface
  assign wren         = !reset && opcode(xm_p2.instr) == OP_SW;
  assign address_dmem = reset ? '0 : xm_p2.result;
  assign data         = xm_p2.b;

  // ---- W: write-back, loads take RAM data here
  assign dest_p3          = dest_reg(mw_p3.instr);
  assign wb_data          = (opcode(mw_p3.instr) == OP_LW) ? q_dmem : mw_p3.result;
  assign ctrl_writeEnable = !reset && dest_p3 != 5'd0;
  assign ctrl_writeReg    = dest_p3;
  assign data_writeReg    = wb_data;

  assign unused_fields = ^{dx_p1.result, mw_p3.pc, mw_p3.a, mw_p3.b};

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_fetch <= RESET_PC;
      pc_p0    <= RESET_PC;
      vld_p0   <= 1'b0;
      dx_p1    <= LATCH_NOP;
      xm_p2    <= LATCH_NOP;
      mw_p3    <= LATCH_NOP;
    end else begin
      mw_p3 <= xm_p2;
      xm_p2 <= xm_next;
      if (taken) begin
        pc_fetch <= target + 32'd1;
        pc_p0    <= target;
        vld_p0   <= 1'b1;
        dx_p1    <= LATCH_NOP;
      end else if (stall) begin
        dx_p1 <= LATCH_NOP;
      end else begin
        pc_fetch <= pc_fetch + 32'd1;
        pc_p0    <= pc_fetch;
        vld_p0   <= 1'b1;
        dx_p1    <= dx_next;
      end
    end
  end

endmodule

// File: tb/tb_pipe5_cpu.sv
// Testbench for pipe5_cpu: models ROM, register file and data RAM, runs a directed
// program and checks architectural results, write timing and reset behaviour.
module tb_pipe5_cpu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  pipe5_cpu dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .wren             (wren),
    .address_dmem     (address_dmem),
    .data             (data),
    .q_dmem           (q_dmem)
  );

  always #5 clock = ~clock;

  logic [31:0] rom  [4096];
  logic [31:0] ram  [4096];
  logic [31:0] regs [32];
  logic        clr_regs;

  always @(posedge clock) q_imem <= rom[address_imem[11:0]];

  always @(posedge clock) begin
    if (wren) ram[address_dmem[11:0]] <= data;
    q_dmem <= ram[address_dmem[11:0]];
  end

  always @(posedge clock) begin
    if (clr_regs) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'h0 : regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'h0 : regs[ctrl_readRegB];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic mon_en = 1'b0;
  int   wr_cnt = 0, r0_wr = 0, wren_cnt = 0;
  int   wr_cyc [32];
  logic [31:0] wren_addr = 32'h0, wren_data = 32'h0;

  always @(negedge clock) begin
    if (mon_en && ctrl_writeEnable) begin
      wr_cnt++;
      wr_cyc[ctrl_writeReg] = cyc;
      if (ctrl_writeReg == 5'd0) r0_wr++;
    end
    if (mon_en && wren) begin
      wren_cnt++;
      wren_addr = address_dmem;
      wren_data = data;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt,
                                        input int sh, input int aop);
    return {5'b00000, rd[4:0], rs[4:0], rt[4:0], sh[4:0], aop[4:0], 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int tgt);
    return {op[4:0], tgt[26:0]};
  endfunction

  initial begin
    reset    = 1'b1;
    clr_regs = 1'b1;
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
    for (int i = 0; i < 32; i++) wr_cyc[i] = 0;
    rom[0]  = i_ins(5, 1, 0, 5);        // addi r1,r0,5
    rom[1]  = i_ins(5, 2, 1, 3);        // addi r2,r1,3
    rom[2]  = i_ins(5, 3, 0, -16);      // addi r3,r0,-16
    rom[3]  = r_ins(4, 3, 0, 2, 5);     // sra r4,r3,2
    rom[4]  = r_ins(5, 1, 0, 1, 4);     // sll r5,r1,1
    rom[5]  = r_ins(6, 1, 2, 0, 1);     // sub r6,r1,r2
    rom[6]  = r_ins(7, 1, 2, 0, 2);     // and r7,r1,r2
    rom[7]  = r_ins(8, 1, 2, 0, 3);     // or  r8,r1,r2
    rom[8]  = i_ins(7, 1, 0, 4);        // sw r1,4(r0)
    rom[9]  = i_ins(8, 9, 0, 4);        // lw r9,4(r0)
    rom[10] = r_ins(10, 9, 9, 0, 0);    // add r10,r9,r9
    rom[11] = i_ins(2, 1, 0, 2);        // bne r1,r0,+2
    rom[12] = i_ins(5, 11, 0, 1);
    rom[13] = i_ins(5, 12, 0, 1);
    rom[14] = i_ins(6, 1, 0, 5);        // blt r1,r0,+5 (not taken)
    rom[15] = i_ins(5, 13, 0, 7);
    rom[16] = j_ins(3, 20);             // jal 20
    rom[17] = i_ins(5, 15, 0, 9);
    rom[18] = j_ins(1, 24);             // j 24
    rom[19] = i_ins(5, 14, 0, 2);
    rom[20] = i_ins(4, 31, 0, 0);       // jr r31
    rom[21] = i_ins(5, 14, 0, 1);
    rom[22] = i_ins(5, 14, 0, 1);
    rom[24] = i_ins(5, 0, 0, 7);        // addi r0,r0,7
    rom[25] = i_ins(5, 16, 0, 3);
    rom[26] = j_ins(1, 26);             // spin

    tick();
    tick();
    check_eq("rst_wren", {31'b0, wren}, 32'h0);
    check_eq("rst_we", {31'b0, ctrl_writeEnable}, 32'h0);
    check_eq("rst_dmem_addr", address_dmem, 32'h0);
    reset    = 1'b0;
    clr_regs = 1'b0;
    check_eq("rst_imem_addr", address_imem, 32'h0);

    mon_en = 1'b1;
    repeat (80) tick();
    mon_en = 1'b0;

    check_eq("r1", regs[1], 32'd5);
    check_eq("r2", regs[2], 32'd8);
    check_eq("r3", regs[3], 32'hFFFF_FFF0);
    check_eq("r4_sra", regs[4], 32'hFFFF_FFFC);
    check_eq("r5_sll", regs[5], 32'd10);
    check_eq("r6_sub", regs[6], 32'hFFFF_FFFD);
    check_eq("r7_and", regs[7], 32'd0);
    check_eq("r8_or", regs[8], 32'd13);
    check_eq("r9_lw", regs[9], 32'd5);
    check_eq("r10_loaduse", regs[10], 32'd10);
    check_eq("r11_skipped", regs[11], 32'd0);
    check_eq("r12_skipped", regs[12], 32'd0);
    check_eq("r13_blt_fallthru", regs[13], 32'd7);
    check_eq("r14_skipped", regs[14], 32'd0);
    check_eq("r15_after_jr", regs[15], 32'd9);
    check_eq("r16", regs[16], 32'd3);
    check_eq("r31_link", regs[31], 32'd17);
    check_eq("r1_r2_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
    check_eq("r9_r10_gap", 32'(wr_cyc[10] - wr_cyc[9]), 32'd2);
    check_eq("write_count", 32'(wr_cnt), 32'd14);
    check_eq("r0_writes", 32'(r0_wr), 32'd0);
    check_eq("wren_cycles", 32'(wren_cnt), 32'd1);
    check_eq("sw_addr", wren_addr, 32'd4);
    check_eq("sw_data", wren_data, 32'd5);

    // restart, then reset again with instructions in flight
    reset    = 1'b1;
    clr_regs = 1'b1;
    tick();
    reset    = 1'b0;
    clr_regs = 1'b0;
    repeat (6) tick();
    reset    = 1'b1;
    clr_regs = 1'b1;
    tick();
    reset    = 1'b0;
    clr_regs = 1'b0;
    check_eq("mid_rst_imem_addr", address_imem, 32'h0);
    check_eq("mid_rst_we", {31'b0, ctrl_writeEnable}, 32'h0);
    check_eq("mid_rst_wren", {31'b0, wren}, 32'h0);
    tick();
    check_eq("post_rst_we1", {31'b0, ctrl_writeEnable}, 32'h0);
    check_eq("post_rst_imem_addr", address_imem, 32'd1);
    tick();
    check_eq("post_rst_we2", {31'b0, ctrl_writeEnable}, 32'h0);
    tick();
    check_eq("post_rst_we3", {31'b0, ctrl_writeEnable}, 32'h0);
    repeat (60) tick();
    check_eq("rerun_r2", regs[2], 32'd8);
    check_eq("rerun_r10", regs[10], 32'd10);
    check_eq("rerun_r14", regs[14], 32'd0);
    check_eq("rerun_r31", regs[31], 32'd17);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
